uart_cmd_rx: RTL and testbench

UART_CMD_RX -- requirements
Module: uart_cmd_rx

---
 rtl/radiometer_pkg.sv | 34 +++
 rtl/uart_rx.sv | 145 ++++++++++++++
 rtl/uart_cmd_rx.sv | 147 ++++++++++++++
 tb/tb_uart_cmd_rx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/radiometer_pkg.sv
// Shared definitions for the radiometer command link: sync byte, FSM encodings,
// command register map and the packet checksum helper.
package radiometer_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;

  // Command register address map
  localparam logic [7:0] REG_CTRL   = 8'h01;
  localparam logic [7:0] REG_GAIN   = 8'h02;
  localparam logic [7:0] REG_OFFSET = 8'h03;
  localparam logic [7:0] REG_INTEG  = 8'h04;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } byte_state_t;

  typedef enum logic [2:0] {
    P_SYNC = 3'd0,
    P_ADDR = 3'd1,
    P_DHI  = 3'd2,
    P_DLO  = 3'd3,
    P_CHK  = 3'd4
  } parser_state_t;

  function automatic logic [7:0] cmd_checksum(input logic [7:0] addr,
                                               input logic [7:0] data_hi,
                                               input logic [7:0] data_lo);
    return addr ^ data_hi ^ data_lo;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// Bit-level UART receiver: synchronizes the pin, samples mid-bit and reports
// each character with byte_valid, or frame_err when the stop bit is low.
module uart_rx
  import radiometer_pkg::*;
#(
  parameter int CLK_HZ       = 32'd100_000_000,
  parameter int BIT_RATE     = 32'd115_200,
  parameter int PAYLOAD_BITS = 32'd8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  output logic                    byte_valid,
  output logic [PAYLOAD_BITS-1:0] byte_data,
  output logic                    frame_err,
  output logic                    busy
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_PERIOD    = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam int BIT_W          = $clog2(PAYLOAD_BITS + 1);

  logic                    rxd_meta_r, rxd_sync_r, rxd_prev_r;
  byte_state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic [BIT_W-1:0]        bit_cnt_r, bit_cnt_nxt_s;
  logic [PAYLOAD_BITS-1:0] shift_r, shift_nxt_s;
  logic                    hold_r, hold_nxt_s;
  logic                    valid_r, valid_nxt_s;
  logic                    ferr_r, ferr_nxt_s;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rxd_meta_r <= 1'b1;
      rxd_sync_r <= 1'b1;
      rxd_prev_r <= 1'b1;
    end else begin
      rxd_meta_r <= uart_rxd;
      rxd_sync_r <= rxd_meta_r;
      rxd_prev_r <= rxd_sync_r;
    end
  end

  // Byte FSM state, counters and registered pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bit_cnt_r <= {BIT_W{1'b0}};
      shift_r   <= {PAYLOAD_BITS{1'b0}};
      hold_r    <= 1'b0;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      hold_r    <= hold_nxt_s;
      valid_r   <= valid_nxt_s;
      ferr_r    <= ferr_nxt_s;
    end
  end

  // Byte FSM next-state logic; hold_r keeps STOP parked until the line recovers
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    hold_nxt_s    = hold_r;
    valid_nxt_s   = 1'b0;
    ferr_nxt_s    = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s     = {CNT_W{1'b0}};
        bit_cnt_nxt_s = {BIT_W{1'b0}};
        hold_nxt_s    = 1'b0;
        if (rxd_prev_r && !rxd_sync_r) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_W'(HALF_PERIOD - 1)) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          if (rxd_sync_r) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      DATA: begin
        if (cnt_r == CNT_W'(CYCLES_PER_BIT - 1)) begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          shift_nxt_s = {rxd_sync_r, shift_r[PAYLOAD_BITS-1:1]};
          if (bit_cnt_r == BIT_W'(PAYLOAD_BITS - 1)) begin
            bit_cnt_nxt_s = {BIT_W{1'b0}};
            state_nxt_s   = STOP;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      STOP: begin
        if (hold_r) begin
          if (rxd_sync_r) begin
            hold_nxt_s  = 1'b0;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = STOP;
          end
        end else if (cnt_r == CNT_W'(CYCLES_PER_BIT - 1)) begin
          cnt_nxt_s = {CNT_W{1'b0}};
          if (rxd_sync_r) begin
            valid_nxt_s = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            ferr_nxt_s = 1'b1;
            hold_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign byte_valid = valid_r;
  assign byte_data  = shift_r;
  assign frame_err  = ferr_r;
  assign busy       = (state_r != IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// UART command receiver: turns A5/addr/data_hi/data_lo/checksum packets into
// register write commands, flagging framing and checksum errors.
module uart_cmd_rx
  import radiometer_pkg::*;
#(
  parameter int CLK_HZ       = 32'd100_000_000,
  parameter int BIT_RATE     = 32'd115_200,
  parameter int PAYLOAD_BITS = 32'd8,
  parameter int GAP_BITS     = 32'd16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        uart_rxd,
  output logic        cmd_valid,
  output logic [7:0]  cmd_addr,
  output logic [15:0] cmd_data,
  output logic        frame_err,
  output logic        chk_err,
  output logic        rx_busy
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int GAP_LIMIT      = GAP_BITS * CYCLES_PER_BIT;
  localparam int GAP_W          = $clog2(GAP_LIMIT + 1);

  logic                    byte_valid_s, byte_ferr_s, byte_busy_s;
  logic [PAYLOAD_BITS-1:0] byte_data_s;
  logic [7:0]              byte8_s;

  parser_state_t pstate_r, pstate_nxt_s;
  logic [7:0]    addr_r, addr_nxt_s, dhi_r, dhi_nxt_s, dlo_r, dlo_nxt_s;
  logic [7:0]    cmd_addr_r, cmd_addr_nxt_s;
  logic [15:0]   cmd_data_r, cmd_data_nxt_s;
  logic          cmd_valid_r, cmd_valid_nxt_s, chk_err_r, chk_err_nxt_s;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt_s;

  uart_rx #(
    .CLK_HZ      (CLK_HZ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(PAYLOAD_BITS)
  ) u_uart_rx (
    .clk       (clk),
    .resetn    (resetn),
    .uart_rxd  (uart_rxd),
    .byte_valid(byte_valid_s),
    .byte_data (byte_data_s),
    .frame_err (byte_ferr_s),
    .busy      (byte_busy_s)
  );

  assign byte8_s = 8'(byte_data_s);

  // Parser state, captured fields and registered command outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pstate_r    <= P_SYNC;
      addr_r      <= 8'h00;
      dhi_r       <= 8'h00;
      dlo_r       <= 8'h00;
      cmd_addr_r  <= 8'h00;
      cmd_data_r  <= 16'h0000;
      cmd_valid_r <= 1'b0;
      chk_err_r   <= 1'b0;
      gap_cnt_r   <= {GAP_W{1'b0}};
    end else begin
      pstate_r    <= pstate_nxt_s;
      addr_r      <= addr_nxt_s;
      dhi_r       <= dhi_nxt_s;
      dlo_r       <= dlo_nxt_s;
      cmd_addr_r  <= cmd_addr_nxt_s;
      cmd_data_r  <= cmd_data_nxt_s;
      cmd_valid_r <= cmd_valid_nxt_s;
      chk_err_r   <= chk_err_nxt_s;
      gap_cnt_r   <= gap_cnt_nxt_s;
    end
  end

  // Packet parser; framing errors and idle gaps abandon a partial packet
  always_comb begin
    pstate_nxt_s    = pstate_r;
    addr_nxt_s      = addr_r;
    dhi_nxt_s       = dhi_r;
    dlo_nxt_s       = dlo_r;
    cmd_addr_nxt_s  = cmd_addr_r;
    cmd_data_nxt_s  = cmd_data_r;
    cmd_valid_nxt_s = 1'b0;
    chk_err_nxt_s   = 1'b0;
    if ((pstate_r == P_SYNC) || byte_busy_s) begin
      gap_cnt_nxt_s = {GAP_W{1'b0}};
    end else begin
      gap_cnt_nxt_s = gap_cnt_r + 1'b1;
    end
    if (byte_ferr_s) begin
      pstate_nxt_s  = P_SYNC;
      gap_cnt_nxt_s = {GAP_W{1'b0}};
    end else if (byte_valid_s) begin
      gap_cnt_nxt_s = {GAP_W{1'b0}};
      case (pstate_r)
        P_SYNC: begin
          if (byte8_s == SYNC_BYTE) begin
            pstate_nxt_s = P_ADDR;
          end else begin
            pstate_nxt_s = P_SYNC;
          end
        end
        P_ADDR: begin
          addr_nxt_s   = byte8_s;
          pstate_nxt_s = P_DHI;
        end
        P_DHI: begin
          dhi_nxt_s    = byte8_s;
          pstate_nxt_s = P_DLO;
        end
        P_DLO: begin
          dlo_nxt_s    = byte8_s;
          pstate_nxt_s = P_CHK;
        end
        P_CHK: begin
          pstate_nxt_s = P_SYNC;
          if (byte8_s == cmd_checksum(addr_r, dhi_r, dlo_r)) begin
            cmd_addr_nxt_s  = addr_r;
            cmd_data_nxt_s  = {dhi_r, dlo_r};
            cmd_valid_nxt_s = 1'b1;
          end else begin
            chk_err_nxt_s = 1'b1;
          end
        end
        default: begin
          pstate_nxt_s = P_SYNC;
        end
      endcase
    end else if ((pstate_r != P_SYNC) && (gap_cnt_r >= GAP_W'(GAP_LIMIT))) begin
      pstate_nxt_s  = P_SYNC;
      gap_cnt_nxt_s = {GAP_W{1'b0}};
    end else begin
      pstate_nxt_s = pstate_r;
    end
  end

  assign cmd_valid = cmd_valid_r;
  assign cmd_addr  = cmd_addr_r;
  assign cmd_data  = cmd_data_r;
  assign chk_err   = chk_err_r;
  assign frame_err = byte_ferr_s;
  assign rx_busy   = byte_busy_s | (pstate_r != P_SYNC);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed and randomized packet stimulus for uart_cmd_rx, checked against a
// queue-based packet model; a faster bit rate keeps the run short.
module tb_uart_cmd_rx;

  localparam int CLK_HZ   = 100_000_000;
  localparam int BIT_RATE = 2_000_000;
  localparam int CPB      = CLK_HZ / BIT_RATE;
  localparam int HALF     = CPB / 2;

  logic        clk;
  logic        resetn;
  logic        uart_rxd;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        frame_err;
  logic        chk_err;
  logic        rx_busy;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_chk = 0, n_ferr = 0;

  logic [7:0]  q[$];
  logic [7:0]  exp_addr = 8'h00;
  logic [15:0] exp_data = 16'h0000;
  int exp_valid = 0, exp_chk = 0, exp_ferr = 0;

  uart_cmd_rx #(
    .CLK_HZ      (CLK_HZ),
    .BIT_RATE    (BIT_RATE),
    .PAYLOAD_BITS(8),
    .GAP_BITS    (16)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .uart_rxd (uart_rxd),
    .cmd_valid(cmd_valid),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .frame_err(frame_err),
    .chk_err  (chk_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid) n_valid <= n_valid + 1;
    if (chk_err)   n_chk   <= n_chk + 1;
    if (frame_err) n_ferr  <= n_ferr + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  // Packet model: collect bytes from a sync byte onwards, judge every fifth
  task automatic model_byte(input logic [7:0] b);
    if (q.size() == 0 && b != 8'hA5) return;
    q.push_back(b);
    if (q.size() == 5) begin
      if ((q[1] ^ q[2] ^ q[3]) == q[4]) begin
        exp_addr = q[1];
        exp_data = {q[2], q[3]};
        exp_valid++;
      end else begin
        exp_chk++;
      end
      q.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_rxd = 1'b0;
    wait_bits(1);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      wait_bits(1);
    end
    uart_rxd = stop_ok;
    wait_bits(1);
    if (stop_ok) begin
      model_byte(b);
    end else begin
      exp_ferr++;
      q.delete();
      uart_rxd = 1'b1;
      wait_bits(1);
    end
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    send_byte(b4, 1'b1);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid_cnt"}, n_valid, exp_valid);
    check({tag, "_chk_cnt"},   n_chk,   exp_chk);
    check({tag, "_ferr_cnt"},  n_ferr,  exp_ferr);
    check({tag, "_addr"},      {24'h0, cmd_addr}, {24'h0, exp_addr});
    check({tag, "_data"},      {16'h0, cmd_data}, {16'h0, exp_data});
  endtask

  initial begin
    logic [7:0] a, hi, lo, ck;
    int waited;
    resetn   = 1'b0;
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_valid", {31'h0, cmd_valid}, 32'h0);
    check("rst_ferr",  {31'h0, frame_err}, 32'h0);
    check("rst_chk",   {31'h0, chk_err},   32'h0);
    check("rst_busy",  {31'h0, rx_busy},   32'h0);
    check("rst_addr",  {24'h0, cmd_addr},  32'h0);
    check("rst_data",  {16'h0, cmd_data},  32'h0);
    resetn = 1'b1;
    wait_bits(2);

    // Bad checksum first: outputs must stay at their reset value
    send_pkt(8'hA5, 8'h01, 8'h12, 8'h34, 8'h00);
    check_all("badchk");
    send_pkt(8'hA5, 8'h01, 8'h12, 8'h34, 8'h27);
    check_all("good1");
    check("good1_busy", {31'h0, rx_busy}, 32'h0);

    // Short glitch on an idle line
    uart_rxd = 1'b0;
    repeat (20) @(negedge clk);
    uart_rxd = 1'b1;
    waited = 0;
    while (rx_busy && waited < HALF + 10) begin
      @(negedge clk);
      waited++;
    end
    check("glitch_busy", {31'h0, rx_busy}, 32'h0);
    wait_bits(1);
    check_all("glitch");

    // Framing error mid-packet, then a clean packet
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h55, 1'b0);
    check_all("ferr");
    check("ferr_busy", {31'h0, rx_busy}, 32'h0);
    send_pkt(8'hA5, 8'h02, 8'h00, 8'h07, 8'h05);
    check_all("after_ferr");

    // Inter-byte timeout discards the partial packet
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    wait_bits(20);
    q.delete();
    check("gap_busy", {31'h0, rx_busy}, 32'h0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h13, 1'b1);
    check_all("gap");

    // Reset in the middle of the third byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    uart_rxd = 1'b0;
    wait_bits(1);
    uart_rxd = 1'b0;
    wait_bits(2);
    resetn = 1'b0;
    uart_rxd = 1'b1;
    q.delete();
    exp_addr = 8'h00;
    exp_data = 16'h0000;
    repeat (3) @(negedge clk);
    check("mid_rst_busy", {31'h0, rx_busy}, 32'h0);
    check("mid_rst_addr", {24'h0, cmd_addr}, {24'h0, exp_addr});
    check("mid_rst_data", {16'h0, cmd_data}, {16'h0, exp_data});
    check("mid_rst_valid", {31'h0, cmd_valid}, 32'h0);
    resetn = 1'b1;
    wait_bits(2);
    send_pkt(8'hA5, 8'h03, 8'hAB, 8'hCD, 8'h65);
    check_all("after_rst");

    // Randomized packets, optionally preceded by a junk byte
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        a = 8'($urandom_range(0, 255));
        if (a == 8'hA5) a = 8'h00;
        send_byte(a, 1'b1);
      end
      a  = 8'($urandom_range(0, 255));
      hi = 8'($urandom_range(0, 255));
      lo = 8'($urandom_range(0, 255));
      ck = a ^ hi ^ lo;
      if ($urandom_range(0, 3) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      send_pkt(8'hA5, a, hi, lo, ck);
      check_all("rand");
    end
    check("final_busy", {31'h0, rx_busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
